vc_flow_ctrl: RTL

Parametrised virtual-channel flow controller for the PCIe transmission layer. It accepts words from the main-FIFO stage and steers each one into one of NUM_VC internal channel FIFOs, selected by the word's VC field. It arbitrates the channels onto a single registered output and honours downstream pause. Programmable per-channel almost-full thresholds are captured during INIT, and an init/idle/active/error state machine reports block status.

---
 rtl/vc_flow_ctrl_pkg.sv | 17 +
 rtl/vc_flow_ctrl_fifo.sv | 61 ++++++
 rtl/vc_flow_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/vc_flow_ctrl_pkg.sv
// Shared definitions for the virtual-channel flow controller:
// state encoding, arbitration mode codes and threshold width.
package vc_flow_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  localparam int unsigned ARB_STRICT = 0;
  localparam int unsigned ARB_RR     = 1;
  localparam int unsigned THR_W      = 4;

endpackage

// File: rtl/vc_flow_ctrl_fifo.sv
// Per-channel synchronous FIFO with occupancy count and a registered
// almost-full flag compared against a programmable threshold.
module vc_fifo
  import vc_flow_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 6,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                         i_clk,
  input  logic                         i_reset_n,
  input  logic                         i_wr,
  input  logic [DATA_WIDTH-1:0]        i_data,
  input  logic                         i_rd,
  input  logic [THR_W-1:0]             i_thr,
  output logic [DATA_WIDTH-1:0]        o_data,
  output logic [$clog2(DEPTH):0]       o_count,
  output logic                         o_empty,
  output logic                         o_full,
  output logic                         o_almost_full
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CW    = AW + 1;
  localparam int unsigned CMP_W = (CW > THR_W) ? CW : THR_W;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wptr;
  logic [AW-1:0]         r_rptr;
  logic [CW-1:0]         r_count;
  logic                  r_af;
  logic [CW-1:0]         w_count_next;

  assign w_count_next = r_count + CW'(i_wr) - CW'(i_rd);

  always_ff @(posedge i_clk) begin
    if (i_wr) r_mem[r_wptr] <= i_data;
  end

  // almost_full is registered from the next count so it tracks the
  // same edge as count/empty while still resetting to 0.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_af    <= 1'b0;
    end else begin
      if (i_wr) r_wptr <= r_wptr + AW'(1);
      if (i_rd) r_rptr <= r_rptr + AW'(1);
      r_count <= w_count_next;
      r_af    <= CMP_W'(w_count_next) >= CMP_W'(i_thr);
    end
  end

  assign o_data        = r_mem[r_rptr];
  assign o_count       = r_count;
  assign o_empty       = (r_count == '0);
  assign o_full        = (r_count == CW'(DEPTH));
  assign o_almost_full = r_af;

endmodule

// File: rtl/vc_flow_ctrl.sv
// Virtual-channel flow controller: steers words into per-VC FIFOs by their
// VC field, arbitrates them onto a registered output and tracks block state.
module vc_flow_ctrl
  import vc_flow_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 6,
  parameter int unsigned NUM_VC     = 2,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned ARB_MODE   = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    init,
  input  logic [4*NUM_VC-1:0]     umbral_vc,
  input  logic                    push,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    out_pause,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    valid_out,
  output logic [NUM_VC-1:0]       almost_full,
  output logic [NUM_VC-1:0]       empty,
  output logic                    idle_out,
  output logic                    active_out,
  output logic                    error_out
);

  localparam int unsigned VC_BITS = $clog2(NUM_VC);
  localparam int unsigned CW      = $clog2(DEPTH) + 1;

  state_t                r_state, w_state_next;
  logic [THR_W-1:0]      r_thr [NUM_VC];
  logic [VC_BITS-1:0]    r_rr_ptr;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_valid_out;

  logic [VC_BITS-1:0]    w_vc;
  logic [NUM_VC-1:0]     w_full, w_empty, w_af, w_wr, w_rd;
  logic [DATA_WIDTH-1:0] w_head [NUM_VC];
  logic [CW-1:0]         w_count [NUM_VC];
  logic                  w_in_service, w_can_pop, w_all_empty, w_overflow;
  logic                  w_grant_valid;
  logic [VC_BITS-1:0]    w_grant, w_idx;

  assign w_vc         = data_in[DATA_WIDTH-1 -: VC_BITS];
  assign w_in_service = (r_state == ST_IDLE) || (r_state == ST_ACTIVE);
  assign w_can_pop    = (w_in_service || (r_state == ST_INIT)) && !out_pause;

  always_comb begin
    w_grant_valid = 1'b0;
    w_grant       = '0;
    w_idx         = '0;
    if (w_can_pop) begin
      for (int unsigned off = 0; off < NUM_VC; off++) begin
        // Strict priority is a round-robin scan anchored at VC0.
        w_idx = (ARB_MODE == ARB_RR) ? r_rr_ptr + VC_BITS'(off) : VC_BITS'(off);
        if (!w_grant_valid && !w_empty[w_idx]) begin
          w_grant_valid = 1'b1;
          w_grant       = w_idx;
        end
      end
    end
  end

  always_comb begin
    w_all_empty = 1'b1;
    for (int unsigned i = 0; i < NUM_VC; i++) begin
      w_rd[i] = w_grant_valid && (w_grant == VC_BITS'(i));
      w_wr[i] = push && w_in_service && (w_vc == VC_BITS'(i)) && (!w_full[i] || w_rd[i]);
      if (w_count[i] != '0) w_all_empty = 1'b0;
    end
  end

  assign w_overflow = push && w_in_service && w_full[w_vc] && !w_rd[w_vc];

  for (genvar g = 0; g < NUM_VC; g++) begin : g_vc
    vc_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
    ) u_fifo (
      .i_clk         (clk),
      .i_reset_n     (reset),
      .i_wr          (w_wr[g]),
      .i_data        (data_in),
      .i_rd          (w_rd[g]),
      .i_thr         (r_thr[g]),
      .o_data        (w_head[g]),
      .o_count       (w_count[g]),
      .o_empty       (w_empty[g]),
      .o_full        (w_full[g]),
      .o_almost_full (w_af[g])
    );
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RESET: w_state_next = ST_INIT;
      ST_INIT:  if (!init && w_all_empty) w_state_next = ST_IDLE;
      ST_IDLE: begin
        if (w_overflow)                   w_state_next = ST_ERROR;
        else if (init)                    w_state_next = ST_INIT;
        else if (push || !w_all_empty)    w_state_next = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (w_overflow)                   w_state_next = ST_ERROR;
        else if (init)                    w_state_next = ST_INIT;
        else if (w_all_empty && !push)    w_state_next = ST_IDLE;
      end
      ST_ERROR: w_state_next = ST_ERROR;
      default:  w_state_next = ST_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_RESET;
      r_rr_ptr    <= '0;
      r_data_out  <= '0;
      r_valid_out <= 1'b0;
      for (int unsigned i = 0; i < NUM_VC; i++) r_thr[i] <= '0;
    end else begin
      r_state     <= w_state_next;
      r_valid_out <= w_grant_valid;
      if (w_grant_valid) begin
        r_data_out <= w_head[w_grant];
        r_rr_ptr   <= w_grant + VC_BITS'(1);
      end
      if (r_state == ST_INIT)
        for (int unsigned i = 0; i < NUM_VC; i++) r_thr[i] <= umbral_vc[4*i +: 4];
    end
  end

  assign data_out    = r_data_out;
  assign valid_out   = r_valid_out;
  assign almost_full = w_af;
  assign empty       = w_empty;
  assign idle_out    = (r_state == ST_IDLE);
  assign active_out  = (r_state == ST_ACTIVE);
  assign error_out   = (r_state == ST_ERROR);

endmodule
